// File: rtl/audio_mix_pkg.sv
// Shared types, widths and helpers for the stereo mix scheduler and its MAC datapath.
package audio_mix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_DONE,
        ST_HOLD
    } state_e;

    typedef enum logic [1:0] {
        SRC_FM_L,
        SRC_FM_R,
        SRC_PSG,
        SRC_SMSFM
    } src_e;

    localparam int MIX_STEPS = 6;
    localparam int ACC_W     = 19;
    localparam int SAMPLE_W  = 16;
    localparam int STEP_W    = 3;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 19'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -19'sd32768;

    // Step order: fm_l->L, fm_r->R, psg->L, psg->R, smsfm->L, smsfm->R.
    function automatic src_e step_src(input logic [STEP_W-1:0] step);
        src_e src;
        case (step)
            3'd0:       src = SRC_FM_L;
            3'd1:       src = SRC_FM_R;
            3'd2, 3'd3: src = SRC_PSG;
            default:    src = SRC_SMSFM;
        endcase
        return src;
    endfunction

    // Odd steps feed the right channel.
    function automatic logic step_is_r(input logic [STEP_W-1:0] step);
        return step[0];
    endfunction

    // Gain index: 0 = fm, 1 = psg, 2 = smsfm.
    function automatic logic [1:0] step_gain(input logic [STEP_W-1:0] step);
        return step[2:1];
    endfunction

    function automatic logic signed [SAMPLE_W-1:0] sat_s16(input logic signed [ACC_W-1:0] a);
        logic signed [SAMPLE_W-1:0] r;
        if (a > SAT_MAX)
            r = 16'sh7FFF;
        else if (a < SAT_MIN)
            r = 16'sh8000;
        else
            r = a[SAMPLE_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/mix_mac.sv
// Single shared gain multiplier with Q1.7 rescale and left/right accumulators.
module mix_mac
    import audio_mix_pkg::*;
#(
    parameter int GW = 8
) (
    input  logic                       clk,
    input  logic                       i_reset_n,
    input  logic                       i_clear,
    input  logic                       i_en,
    input  logic [STEP_W-1:0]          i_step,
    input  logic signed [SAMPLE_W-1:0] i_fm_l,
    input  logic signed [SAMPLE_W-1:0] i_fm_r,
    input  logic signed [SAMPLE_W-1:0] i_psg,
    input  logic signed [SAMPLE_W-1:0] i_smsfm,
    input  logic [GW-1:0]              i_gain_fm,
    input  logic [GW-1:0]              i_gain_psg,
    input  logic [GW-1:0]              i_gain_smsfm,
    output logic signed [ACC_W-1:0]    o_acc_l,
    output logic signed [ACC_W-1:0]    o_acc_r
);

    localparam int PROD_W = SAMPLE_W + GW + 1;

    logic signed [SAMPLE_W-1:0] w_sample;
    logic [GW-1:0]              w_gain;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]    w_addend;
    logic signed [ACC_W-1:0]    r_acc_l;
    logic signed [ACC_W-1:0]    r_acc_r;

    always_comb begin
        w_sample = i_fm_l;
        case (step_src(i_step))
            SRC_FM_L:  w_sample = i_fm_l;
            SRC_FM_R:  w_sample = i_fm_r;
            SRC_PSG:   w_sample = i_psg;
            SRC_SMSFM: w_sample = i_smsfm;
            default:   w_sample = i_fm_l;
        endcase

        w_gain = i_gain_fm;
        case (step_gain(i_step))
            2'd0:    w_gain = i_gain_fm;
            2'd1:    w_gain = i_gain_psg;
            default: w_gain = i_gain_smsfm;
        endcase

        // Gain is unsigned; a zero MSB keeps it positive in the signed product.
        w_prod   = PROD_W'(w_sample) * PROD_W'($signed({1'b0, w_gain}));
        w_addend = ACC_W'(w_prod >>> 7);
    end

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            r_acc_l <= '0;
            r_acc_r <= '0;
        end else if (i_clear) begin
            r_acc_l <= '0;
            r_acc_r <= '0;
        end else if (i_en) begin
            if (step_is_r(i_step))
                r_acc_r <= r_acc_r + w_addend;
            else
                r_acc_l <= r_acc_l + w_addend;
        end
    end

    assign o_acc_l = r_acc_l;
    assign o_acc_r = r_acc_r;

endmodule

// File: rtl/audio_mix_sched.sv
// Frame-tick driven stereo mix scheduler: holds latest source samples, runs six
// shared-multiplier products per frame and hands a saturated sample downstream.
//
// state | meaning
// IDLE  | waiting for frame_tick
// MAC   | one product per cycle, steps 0..5
// DONE  | saturate/mute accumulators into output registers
// HOLD  | out_valid high until out_ready
module audio_mix_sched
    import audio_mix_pkg::*;
#(
    parameter int GW = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       mute,
    input  logic                       fm_l_stb,
    input  logic                       fm_r_stb,
    input  logic                       psg_stb,
    input  logic                       smsfm_stb,
    input  logic signed [SAMPLE_W-1:0] fm_l_in,
    input  logic signed [SAMPLE_W-1:0] fm_r_in,
    input  logic signed [SAMPLE_W-1:0] psg_in,
    input  logic signed [SAMPLE_W-1:0] smsfm_in,
    input  logic [GW-1:0]              gain_fm,
    input  logic [GW-1:0]              gain_psg,
    input  logic [GW-1:0]              gain_smsfm,
    input  logic                       frame_tick,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [SAMPLE_W-1:0] out_l,
    output logic signed [SAMPLE_W-1:0] out_r,
    output logic                       busy,
    output logic [7:0]                 drop_cnt
);

    state_e r_state;
    state_e w_state_nxt;
    logic   w_accept;
    logic   w_mac_en;

    logic [STEP_W-1:0]          r_step;
    logic signed [SAMPLE_W-1:0] r_hold_fm_l, r_hold_fm_r, r_hold_psg, r_hold_smsfm;
    logic signed [SAMPLE_W-1:0] r_work_fm_l, r_work_fm_r, r_work_psg, r_work_smsfm;
    logic [GW-1:0]              r_work_gain_fm, r_work_gain_psg, r_work_gain_smsfm;
    logic signed [SAMPLE_W-1:0] r_out_l, r_out_r;
    logic                       r_out_valid;
    logic [7:0]                 r_drop_cnt;
    logic signed [ACC_W-1:0]    w_acc_l, w_acc_r;

    always_comb begin
        w_state_nxt = r_state;
        w_mac_en    = 1'b0;
        w_accept    = frame_tick &&
                      ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready));
        case (r_state)
            ST_IDLE: begin
                if (w_accept)
                    w_state_nxt = ST_MAC;
            end
            ST_MAC: begin
                w_mac_en = 1'b1;
                if (r_step == STEP_W'(MIX_STEPS - 1))
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (out_ready)
                    w_state_nxt = w_accept ? ST_MAC : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state           <= ST_IDLE;
            r_step            <= '0;
            r_hold_fm_l       <= '0;
            r_hold_fm_r       <= '0;
            r_hold_psg        <= '0;
            r_hold_smsfm      <= '0;
            r_work_fm_l       <= '0;
            r_work_fm_r       <= '0;
            r_work_psg        <= '0;
            r_work_smsfm      <= '0;
            r_work_gain_fm    <= '0;
            r_work_gain_psg   <= '0;
            r_work_gain_smsfm <= '0;
            r_out_l           <= '0;
            r_out_r           <= '0;
            r_out_valid       <= 1'b0;
            r_drop_cnt        <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (fm_l_stb)  r_hold_fm_l  <= fm_l_in;
            if (fm_r_stb)  r_hold_fm_r  <= fm_r_in;
            if (psg_stb)   r_hold_psg   <= psg_in;
            if (smsfm_stb) r_hold_smsfm <= smsfm_in;

            // Snapshot reads the holding registers before any same-edge strobe lands.
            if (w_accept) begin
                r_work_fm_l       <= r_hold_fm_l;
                r_work_fm_r       <= r_hold_fm_r;
                r_work_psg        <= r_hold_psg;
                r_work_smsfm      <= r_hold_smsfm;
                r_work_gain_fm    <= gain_fm;
                r_work_gain_psg   <= gain_psg;
                r_work_gain_smsfm <= gain_smsfm;
                r_step            <= '0;
            end else if (w_mac_en) begin
                r_step <= r_step + 1'b1;
            end

            if (r_state == ST_DONE) begin
                r_out_l     <= mute ? '0 : sat_s16(w_acc_l);
                r_out_r     <= mute ? '0 : sat_s16(w_acc_r);
                r_out_valid <= 1'b1;
            end else if ((r_state == ST_HOLD) && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (frame_tick && !w_accept && (r_drop_cnt != 8'hFF))
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    mix_mac #(.GW(GW)) u_mix_mac (
        .clk          (clk),
        .i_reset_n    (reset_n),
        .i_clear      (w_accept),
        .i_en         (w_mac_en),
        .i_step       (r_step),
        .i_fm_l       (r_work_fm_l),
        .i_fm_r       (r_work_fm_r),
        .i_psg        (r_work_psg),
        .i_smsfm      (r_work_smsfm),
        .i_gain_fm    (r_work_gain_fm),
        .i_gain_psg   (r_work_gain_psg),
        .i_gain_smsfm (r_work_gain_smsfm),
        .o_acc_l      (w_acc_l),
        .o_acc_r      (w_acc_r)
    );

    assign out_l     = r_out_l;
    assign out_r     = r_out_r;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != ST_IDLE);
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_audio_mix_sched.sv
// Directed bench for audio_mix_sched with hand-computed mix results.
module tb_audio_mix_sched;

    logic        clk = 1'b0;
    logic        reset_n, mute, frame_tick, out_ready;
    logic        fm_l_stb, fm_r_stb, psg_stb, smsfm_stb;
    logic [15:0] fm_l_in, fm_r_in, psg_in, smsfm_in;
    logic [7:0]  gain_fm, gain_psg, gain_smsfm;
    logic        out_valid, busy;
    logic [15:0] out_l, out_r;
    logic [7:0]  drop_cnt;

    int n_total = 0;
    int n_bad   = 0;
    int exp_drop;
    logic seen_valid;

    always #5 clk = ~clk;

    audio_mix_sched #(.GW(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mute       (mute),
        .fm_l_stb   (fm_l_stb),
        .fm_r_stb   (fm_r_stb),
        .psg_stb    (psg_stb),
        .smsfm_stb  (smsfm_stb),
        .fm_l_in    (fm_l_in),
        .fm_r_in    (fm_r_in),
        .psg_in     (psg_in),
        .smsfm_in   (smsfm_in),
        .gain_fm    (gain_fm),
        .gain_psg   (gain_psg),
        .gain_smsfm (gain_smsfm),
        .frame_tick (frame_tick),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_l      (out_l),
        .out_r      (out_r),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] fl, input logic [15:0] fr,
                        input logic [15:0] ps, input logic [15:0] sm);
        fm_l_in = fl; fm_r_in = fr; psg_in = ps; smsfm_in = sm;
        fm_l_stb = 1'b1; fm_r_stb = 1'b1; psg_stb = 1'b1; smsfm_stb = 1'b1;
        step();
        fm_l_stb = 1'b0; fm_r_stb = 1'b0; psg_stb = 1'b0; smsfm_stb = 1'b0;
    endtask

    task automatic set_gains(input logic [7:0] gf, input logic [7:0] gp, input logic [7:0] gs);
        gain_fm = gf; gain_psg = gp; gain_smsfm = gs;
    endtask

    // Full frame with out_ready high: tick at E0, valid at E7, handshake at E8.
    task automatic do_frame(input string tag, input logic [15:0] el, input logic [15:0] er);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        fm_l_stb   = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        repeat (6) step();
        chk({tag, "_early"}, out_valid, 0);
        step();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_l"}, out_l, el);
        chk({tag, "_r"}, out_r, er);
        step();
        chk({tag, "_vclr"}, out_valid, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        reset_n = 1'b0; mute = 1'b0; frame_tick = 1'b0; out_ready = 1'b1;
        fm_l_stb = 1'b0; fm_r_stb = 1'b0; psg_stb = 1'b0; smsfm_stb = 1'b0;
        fm_l_in = '0; fm_r_in = '0; psg_in = '0; smsfm_in = '0;
        set_gains(8'h00, 8'h00, 8'h00);
        exp_drop = 0;
        repeat (3) step();
        chk("rst_valid", out_valid, 0);
        chk("rst_l", out_l, 0);
        chk("rst_r", out_r, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_cnt, 0);
        reset_n = 1'b1;
        step();

        load(16'h1000, 16'h0000, 16'h0000, 16'h0000);
        set_gains(8'h80, 8'h00, 8'h00);
        do_frame("unity", 16'h1000, 16'h0000);

        load(16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF);
        set_gains(8'hFF, 8'hFF, 8'hFF);
        do_frame("psat", 16'h7FFF, 16'h7FFF);

        load(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        do_frame("nsat", 16'h8000, 16'h8000);

        load(16'h0000, 16'h0000, 16'h2000, 16'h0000);
        set_gains(8'h80, 8'h40, 8'h80);
        do_frame("gain", 16'h1000, 16'h1000);
        mute = 1'b1;
        do_frame("mute", 16'h0000, 16'h0000);
        mute = 1'b0;

        // Tick rejected at E3, then a long stall in HOLD, then tick on the handshake.
        out_ready  = 1'b0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (2) step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        exp_drop = 1;
        chk("mac_drop", drop_cnt, exp_drop);
        repeat (4) step();
        chk("mac_valid", out_valid, 1);
        chk("mac_l", out_l, 16'h1000);
        chk("mac_r", out_r, 16'h1000);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_stable", {out_valid, out_l, out_r}, {1'b1, 16'h1000, 16'h1000});
        end
        out_ready  = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("b2b_drop", drop_cnt, exp_drop);
        chk("b2b_busy", busy, 1);
        chk("b2b_vclr", out_valid, 0);
        repeat (6) step();
        chk("b2b_early", out_valid, 0);
        step();
        chk("b2b_valid", out_valid, 1);
        chk("b2b_l", out_l, 16'h1000);
        step();
        chk("b2b_vclr2", out_valid, 0);

        // Strobe on the tick edge: snapshot keeps the old value.
        load(16'h0100, 16'h0000, 16'h0000, 16'h0000);
        set_gains(8'h80, 8'h80, 8'h80);
        fm_l_stb = 1'b1;
        fm_l_in  = 16'h0200;
        do_frame("strb_old", 16'h0100, 16'h0000);
        do_frame("strb_new", 16'h0200, 16'h0000);

        // Drop counter saturation while stalled in HOLD.
        out_ready  = 1'b0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (7) step();
        frame_tick = 1'b1;
        repeat (300) step();
        frame_tick = 1'b0;
        chk("drop_sat", drop_cnt, 8'hFF);
        chk("drop_sat_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        chk("drop_sat_vclr", out_valid, 0);

        // Reset at E4 of a frame.
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (3) step();
        reset_n = 1'b0;
        step();
        chk("mrst_l", out_l, 0);
        chk("mrst_r", out_r, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_drop", drop_cnt, 0);
        reset_n = 1'b1;
        seen_valid = 1'b0;
        repeat (10) begin
            step();
            if (out_valid) seen_valid = 1'b1;
        end
        chk("mrst_novalid", seen_valid, 0);
        do_frame("post_rst", 16'h0000, 16'h0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
